// File: rtl/state_dump_unit.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : state_dump_unit
// Description : Freezes the core, then streams every register-file word and
//               every data-memory word out over a valid/ready port.
// Revision    : 1.0 - initial release
// ============================================================================
module state_dump_unit #(
    parameter int DATA_WIDTH     = 16,
    parameter int REG_ADDR_WIDTH = 4,
    parameter int REG_COUNT      = 16,
    parameter int MEM_ADDR_WIDTH = 8,
    parameter int MEM_DEPTH      = 256
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic                      start,
    output logic                      cpu_halt,
    output logic                      busy,
    output logic                      done,
    output logic [REG_ADDR_WIDTH-1:0] reg_addr,
    input  logic [DATA_WIDTH-1:0]     reg_data,
    output logic [MEM_ADDR_WIDTH-1:0] mem_addr,
    input  logic [DATA_WIDTH-1:0]     mem_data,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [DATA_WIDTH-1:0]     out_data,
    output logic                      out_src,
    output logic                      out_last
);

    // One extra count value so the counters can reach REG_COUNT / MEM_DEPTH.
    localparam int c_reg_cw = $clog2(REG_COUNT + 1);
    localparam int c_mem_cw = $clog2(MEM_DEPTH + 1);

    localparam logic [c_reg_cw-1:0] c_reg_last = c_reg_cw'(REG_COUNT - 1);
    localparam logic [c_mem_cw-1:0] c_mem_last = c_mem_cw'(MEM_DEPTH - 1);
    localparam logic [c_mem_cw-1:0] c_mem_end  = c_mem_cw'(MEM_DEPTH);

    localparam logic [1:0] c_st_idle = 2'd0;
    localparam logic [1:0] c_st_regs = 2'd1;
    localparam logic [1:0] c_st_mems = 2'd2;
    localparam logic [1:0] c_st_done = 2'd3;

    logic [1:0]            r_state;
    logic [c_reg_cw-1:0]   r_reg_cnt;
    logic [c_mem_cw-1:0]   r_mem_cnt;
    logic                  r_out_valid;
    logic [DATA_WIDTH-1:0] r_out_data;
    logic                  r_out_src;
    logic                  r_out_last;
    logic                  w_free;

    assign w_free    = !r_out_valid || out_ready;

    assign reg_addr  = r_reg_cnt[REG_ADDR_WIDTH-1:0];
    assign mem_addr  = r_mem_cnt[MEM_ADDR_WIDTH-1:0];

    assign cpu_halt  = (r_state == c_st_regs) || (r_state == c_st_mems);
    assign busy      = (r_state == c_st_regs) || (r_state == c_st_mems);
    assign done      = (r_state == c_st_done);

    assign out_valid = r_out_valid;
    assign out_data  = r_out_data;
    assign out_src   = r_out_src;
    assign out_last  = r_out_last;

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state     <= c_st_idle;
            r_reg_cnt   <= '0;
            r_mem_cnt   <= '0;
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            r_out_src   <= 1'b0;
            r_out_last  <= 1'b0;
        end else begin
            case (r_state)
                c_st_idle: begin
                    if (start) begin
                        r_state   <= c_st_regs;
                        r_reg_cnt <= '0;
                        r_mem_cnt <= '0;
                    end
                end
                c_st_regs: begin
                    if (w_free) begin
                        r_out_valid <= 1'b1;
                        r_out_data  <= reg_data;
                        r_out_src   <= 1'b0;
                        r_out_last  <= 1'b0;
                        r_reg_cnt   <= r_reg_cnt + 1'b1;
                        // Memory reads start on the very next free cycle: no bubble.
                        if (r_reg_cnt == c_reg_last) begin
                            r_state <= c_st_mems;
                        end
                    end
                end
                c_st_mems: begin
                    if (w_free) begin
                        if (r_mem_cnt != c_mem_end) begin
                            r_out_valid <= 1'b1;
                            r_out_data  <= mem_data;
                            r_out_src   <= 1'b1;
                            r_out_last  <= (r_mem_cnt == c_mem_last);
                            r_mem_cnt   <= r_mem_cnt + 1'b1;
                        end else begin
                            // Final word has just been accepted.
                            r_out_valid <= 1'b0;
                            r_out_last  <= 1'b0;
                            r_state     <= c_st_done;
                        end
                    end
                end
                c_st_done: begin
                    r_state <= c_st_idle;
                end
                default: begin
                    r_state <= c_st_idle;
                end
            endcase
        end
    end

endmodule
`default_nettype wire
